// File: rtl/ram_stream_reader.sv
// Read-side burst master for the 16x8 dual-port RAM: issues a contiguous,
// wrapping run of reads and streams the returned bytes over valid/ready.
module ram_stream_reader #(
    parameter int ram_width = 8,
    parameter int addr_size = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addr_size-1:0] start_addr,
    input  logic [addr_size:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_read,
    output logic [addr_size-1:0] ram_rd_addr,
    input  logic [ram_width-1:0] ram_data_out,
    output logic [ram_width-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [addr_size-1:0]   addr;
    logic [addr_size:0]     remaining;
    logic                   inflight;
    logic [ram_width-1:0]   fifo_mem [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             occupancy;

    logic                   load;
    logic                   pop;
    logic                   push;
    logic [1:0]             occ_after_pop;
    logic [2:0]             level;
    logic                   credit;

    assign pop           = out_valid && out_ready;
    assign push          = inflight;
    assign occ_after_pop = occupancy - {1'b0, pop};

    // A read is only issued if its byte is guaranteed a buffer slot when it returns.
    assign level  = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    assign credit = (level < 3'd2);

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign ram_rd_addr = addr;
    assign out_valid   = (occupancy != 2'd0);
    assign out_data    = fifo_mem[rd_ptr];

    always_comb begin
        state_next = state;
        ram_read   = 1'b0;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_next = S_RUN;
                        load       = 1'b1;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                ram_read = (remaining != '0) && credit;
                if ((remaining == '0) && !inflight && (occ_after_pop == 2'd0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= ram_read;
            if (load) begin
                addr      <= start_addr;
                remaining <= length;
            end else if (ram_read) begin
                addr      <= addr + addr_size'(1);
                remaining <= remaining - (addr_size + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_data_out;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural one-cycle-latency
// RAM read port preloaded with RAM[i] = 8'hA0 + i.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] length = '0;
    logic       busy;
    logic       done;
    logic       ram_read;
    logic [3:0] ram_rd_addr;
    logic [7:0] ram_data_out = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    logic [7:0] mem [16];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_stream_reader #(.ram_width(8), .addr_size(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_read    (ram_read),
        .ram_rd_addr (ram_rd_addr),
        .ram_data_out(ram_data_out),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always @(posedge clk) begin
        if (ram_read) ram_data_out <= mem[ram_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One burst; stalls out_ready for stall_cycles once stall_after bytes have moved.
    task automatic run_burst(input logic [3:0] sa, input logic [4:0] len,
                             input int stall_after, input int stall_cycles, input bit inject);
        int reads = 0;
        int pops = 0;
        int dones = 0;
        int first_valid = -1;
        int last_pop = -1;
        int stall_left = stall_cycles;
        int outstanding;
        bit finished = 0;
        bit p;
        logic [3:0] ea;
        logic [7:0] eb;

        @(negedge clk);
        start = 1'b1; start_addr = sa; length = len; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && !finished; k++) begin
            if (inject && k == 3) begin
                start = 1'b1; start_addr = 4'd9; length = 5'd8;
            end else if (inject && k == 4) begin
                start = 1'b0;
            end
            out_ready = !(pops == stall_after && stall_left > 0);
            if (!out_ready) stall_left--;
            #1;
            p = out_valid && out_ready;
            if (k == 0) check_eq("read_at_start", ram_read, len != 0);
            outstanding = reads - pops;
            check_eq("max_outstanding", outstanding > 2, 0);
            if (outstanding - int'(p) >= 2) check_eq("read_when_full", ram_read, 0);
            if (ram_read) begin
                ea = sa + reads[3:0];
                check_eq("rd_addr", ram_rd_addr, ea);
                reads++;
            end
            if (out_valid) begin
                if (first_valid < 0) begin
                    first_valid = k;
                    check_eq("first_valid_cycle", k, 2);
                end
                ea = sa + pops[3:0];
                eb = 8'hA0 + {4'h0, ea};
                check_eq("out_data", out_data, eb);
            end
            if (p) begin
                pops++;
                last_pop = k;
            end
            if (done) begin
                dones++;
                check_eq("done_cycle", k, last_pop + 1);
                check_eq("busy_in_done", busy, 1);
                check_eq("valid_in_done", out_valid, 0);
                @(posedge clk); #2;
                check_eq("busy_after", busy, 0);
                check_eq("done_single", done, 0);
                finished = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_eq("burst_finished", finished, 1);
        check_eq("read_count", reads, len);
        check_eq("byte_count", pops, len);
        check_eq("done_count", dones, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ram_read", ram_read, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_addr", ram_rd_addr, 0);
        check_eq("rst_data", out_data, 0);
        @(negedge clk); reset = 1'b1;

        run_burst(4'd3, 5'd4, -1, 0, 0);
        run_burst(4'd14, 5'd4, -1, 0, 0);
        run_burst(4'd0, 5'd16, 1, 5, 0);
        run_burst(4'd7, 5'd0, -1, 0, 0);
        run_burst(4'd2, 5'd8, -1, 0, 1);

        // Asynchronous reset mid-burst
        @(negedge clk);
        start = 1'b1; start_addr = 4'd0; length = 5'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("pre_rst_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_read", ram_read, 0);
        check_eq("arst_data", out_data, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("arst_no_done", done, 0);
        end
        reset = 1'b1;
        run_burst(4'd5, 5'd2, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for the 16x8 dual-port RAM (dual_ram_16_8).
- On a start command it issues a burst of RAM reads over a contiguous address range, with wrap-around.
- It absorbs the RAM's one-cycle read latency and streams the returned bytes out on a valid/ready interface.
- It sits between the RAM read port and any downstream consumer, and is the counterpart to the write-side stimulus that fills the RAM.

Parameters:
- ram_width, 8, data width of the RAM and of the output stream.
- addr_size, 4, RAM address width; RAM depth = 2**addr_size.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  burst request, sampled only in IDLE.
- start_addr  input  addr_size  first RAM address of the burst.
- length  input  addr_size+1  number of bytes to read, 0..16.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the burst has fully drained.
- ram_read  output  1  read enable to the RAM read port.
- ram_rd_addr  output  addr_size  read address to the RAM.
- ram_data_out  input  ram_width  RAM read data, valid the cycle after a sampled ram_read.
- out_data  output  ram_width  stream data.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer accepts data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy, done, ram_read, out_valid = 0; ram_rd_addr, out_data = 0.
  - Address counter, remaining count, in-flight flag and buffer are cleared.
  - Any burst in progress is abandoned; no done pulse is produced.
- RAM timing contract: ram_read=1 at rising edge E causes data for ram_rd_addr to appear on ram_data_out after E. The reader captures it at edge E+1.
- States:
  - IDLE: start=1 with length!=0 goes to RUN, loading addr=start_addr and remaining=length. start=1 with length=0 goes directly to DONE, issuing no reads. start=0 stays in IDLE.
  - RUN: ram_read = (remaining!=0) && credit, where credit = (occupancy + inflight - pop) < 2.
    - pop = out_valid && out_ready.
    - occupancy = output buffer entries (0..2).
    - inflight = 1 if a read was issued on the previous edge.
    - On each issued read: addr <= addr+1 modulo 2**addr_size (15 wraps to 0), and remaining <= remaining-1.
    - Transition to DONE when remaining==0, inflight==0 and occupancy==0 after the pop.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Output buffer:
  - Two-entry FIFO; out_data is the head entry, out_valid = (occupancy!=0).
  - Returned RAM data is pushed at the capture edge. A push and a pop in the same cycle are both performed.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - Bytes are never dropped or duplicated; stream order equals address order.
- Latency and throughput:
  - With start sampled at edge N: ram_read is high from N, first RAM data is captured at N+2, and out_valid first goes high after N+2.
  - With out_ready held high, one byte is delivered per cycle, back-to-back.
  - done is asserted the cycle after the last byte transfers.
- start asserted while busy is ignored. start_addr and length are sampled only on the accepting edge.
- ram_rd_addr always shows the address counter. ram_read is never asserted outside RUN.

Test Plan:
- Preload RAM[i]=8'hA0+i; reset; start with start_addr=3, length=4, out_ready=1 -> ram_rd_addr sequence 3,4,5,6. out_data is 8'hA3, A4, A5, A6 on four consecutive cycles, first out_valid 2 cycles after the start edge, done one cycle after the 8'hA6 transfer, busy low afterwards.
- start_addr=14, length=4 -> addresses 14,15,0,1; out_data 8'hAE, AF, A0, A1.
- start_addr=0, length=16, out_ready low for 5 cycles after the second byte -> out_data holds 8'hA1 stable. At most 2 reads are outstanding and buffered, and ram_read stays low while the buffer is full. All 16 bytes 8'hA0..8'hAF arrive in order with no gaps or repeats, then a single done pulse.
- length=0 -> no ram_read; done=1 on the cycle after the start edge; out_valid never asserts.
- During a length-8 burst, pulse start with start_addr=9 -> ignored; the burst continues unchanged and exactly 8 bytes are delivered.
- Drive reset=0 asynchronously mid-burst (between clock edges) -> out_valid, busy and ram_read drop immediately, with no done pulse. After release, a fresh start with start_addr=5, length=2 delivers 8'hA5, 8'hA6.
